// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register countdown counters plus pending bits
// track in-flight producers and raise hz for RAW/WAW conflicts in IF/ID.

module hazard_sb_entry #(
    parameter int CTW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ld_fix,
    input  logic           ld_var,
    input  logic [CTW-1:0] ld_val,
    input  logic           wb_clr,
    output logic [CTW-1:0] cnt,
    output logic           pend
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            pend <= 1'b0;
        end else begin
            if (ld_fix)
                cnt <= ld_val;
            else if (ld_var)
                cnt <= '0;
            else if (cnt != '0)
                cnt <= cnt - CTW'(1);
            // a new variable-latency producer outranks a write-back to the same register
            if (ld_var)
                pend <= 1'b1;
            else if (wb_clr)
                pend <= 1'b0;
        end
    end
endmodule

module hazard_scoreboard #(
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int MAXLAT   = 6,
    parameter int BR_EXTRA = 1,
    parameter int CW       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [AW-1:0]               id_rs1,
    input  logic [AW-1:0]               id_rs2,
    input  logic                        id_rs1_used,
    input  logic                        id_rs2_used,
    input  logic                        id_branch,
    input  logic [AW-1:0]               id_rd,
    input  logic                        id_regwrite,
    input  logic [$clog2(MAXLAT+1)-1:0] id_lat,
    input  logic                        id_varlat,
    input  logic                        flush,
    input  logic                        wb_valid,
    input  logic [AW-1:0]               wb_rd,
    output logic                        hz,
    output logic                        sb_busy,
    output logic [CW-1:0]               stall_cycles
);
    localparam int LW  = $clog2(MAXLAT+1);
    localparam int CTW = $clog2(MAXLAT+BR_EXTRA+1);
    localparam logic [CTW-1:0] BRX = CTW'(BR_EXTRA);

    typedef struct packed {
        logic           fix;
        logic           varlat;
        logic [AW-1:0]  rd;
        logic [CTW-1:0] lat;
    } wr_req_t;

    logic [NREG-1:0][CTW-1:0] cnt;
    logic [NREG-1:0]          pend;
    logic [CTW-1:0]           lat_ext;
    logic                     raw1, raw2, waw, issue;
    wr_req_t                  wr;

    assign cnt[0]  = '0;
    assign pend[0] = 1'b0;

    // counter value a fixed producer loads: ready for EX when it reaches BR_EXTRA, for a branch at 0
    assign lat_ext = CTW'(id_lat) + BRX;

    assign raw1 = id_rs1_used && (id_rs1 != '0) &&
                  (pend[id_rs1] || (id_branch ? (cnt[id_rs1] != '0) : (cnt[id_rs1] > BRX)));
    assign raw2 = id_rs2_used && (id_rs2 != '0) &&
                  (pend[id_rs2] || (id_branch ? (cnt[id_rs2] != '0) : (cnt[id_rs2] > BRX)));
    // a younger fixed producer must not complete ahead of the older write to the same rd
    assign waw  = id_regwrite && (id_rd != '0) &&
                  (pend[id_rd] || (!id_varlat && (cnt[id_rd] > lat_ext)));

    assign hz      = id_valid && !flush && (raw1 || raw2 || waw);
    assign issue   = id_valid && !flush && !hz;
    assign sb_busy = (|cnt) || (|pend);

    always_comb begin
        wr        = '0;
        wr.fix    = issue && id_regwrite && !id_varlat;
        wr.varlat = issue && id_regwrite && id_varlat;
        wr.rd     = id_rd;
        wr.lat    = lat_ext;
    end

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        hazard_sb_entry #(.CTW(CTW)) u_ent (
            .clk    (clk),
            .rst_n  (rst_n),
            .ld_fix (wr.fix && (wr.rd == AW'(r))),
            .ld_var (wr.varlat && (wr.rd == AW'(r))),
            .ld_val (wr.lat),
            .wb_clr (wb_valid && (wb_rd == AW'(r))),
            .cnt    (cnt[r]),
            .pend   (pend[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (hz && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CW'(1);
    end

    always @(posedge clk) begin
        if (rst_n && id_valid && !flush)
            assert (id_lat <= LW'(MAXLAT))
            else $error("hazard_scoreboard: id_lat %0d exceeds MAXLAT %0d", id_lat, MAXLAT);
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed vector table, hand sequences and a timestamp-based reference model
// for hazard_scoreboard; a CW=4 twin checks stall counter saturation.

module tb_hazard_scoreboard;
    localparam int NREG = 32, AW = 5, MAXLAT = 6, BR = 1, LW = 3;

    logic clk = 1'b0, rst_n = 1'b0;
    logic id_valid, id_rs1_used, id_rs2_used, id_branch, id_regwrite, id_varlat, flush, wb_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic [LW-1:0] id_lat;
    logic hz, sb_busy, hz4, busy4;
    logic [15:0] stall_cycles;
    logic [3:0]  stall4;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAXLAT(MAXLAT), .BR_EXTRA(BR), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_branch(id_branch),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_lat(id_lat), .id_varlat(id_varlat),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .hz(hz), .sb_busy(sb_busy), .stall_cycles(stall_cycles));

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAXLAT(MAXLAT), .BR_EXTRA(BR), .CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_branch(id_branch),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_lat(id_lat), .id_varlat(id_varlat),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .hz(hz4), .sb_busy(busy4), .stall_cycles(stall4));

    typedef struct {
        bit v; int rs1; bit u1; int rs2; bit u2; bit br;
        int rd; bit rw; int lat; bit vl; bit fl; bit wbv; int wbrd;
        bit ehz;
    } vec_t;

    int n_cmp = 0, n_err = 0;

    // reference model: cycle at which each register's counter would read zero
    int done_at[NREG];
    bit pend_m[NREG];
    int cyc = 0, stall_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (model cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(bit v, int rs1, bit u1, int rs2, bit u2, bit br,
                                int rd, bit rw, int lat, bit vl, bit fl, bit ehz);
        vec_t x;
        x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2; x.br = br;
        x.rd = rd; x.rw = rw; x.lat = lat; x.vl = vl; x.fl = fl;
        x.wbv = 1'b0; x.wbrd = 0; x.ehz = ehz;
        return x;
    endfunction

    function automatic vec_t wbx(vec_t x, int r);
        vec_t y = x;
        y.wbv = 1'b1; y.wbrd = r;
        return y;
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit raw_m(int rs, bit used, bit br);
        if (!used || rs == 0) return 1'b0;
        if (pend_m[rs]) return 1'b1;
        // EX consumer may read BR cycles before a branch in ID may
        return br ? (cyc < done_at[rs]) : (cyc < done_at[rs] - BR);
    endfunction

    function automatic bit hz_m(vec_t x);
        bit waw;
        if (!x.v || x.fl) return 1'b0;
        waw = x.rw && x.rd != 0 &&
              (pend_m[x.rd] || (!x.vl && (done_at[x.rd] - cyc > x.lat + BR)));
        return raw_m(x.rs1, x.u1, x.br) || raw_m(x.rs2, x.u2, x.br) || waw;
    endfunction

    function automatic bit busy_m();
        for (int r = 1; r < NREG; r++)
            if (pend_m[r] || done_at[r] > cyc) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            done_at[r] = 0;
            pend_m[r]  = 1'b0;
        end
        stall_m = 0;
    endtask

    task automatic apply(vec_t x);
        id_valid = x.v; id_rs1 = AW'(x.rs1); id_rs1_used = x.u1;
        id_rs2 = AW'(x.rs2); id_rs2_used = x.u2; id_branch = x.br;
        id_rd = AW'(x.rd); id_regwrite = x.rw; id_lat = LW'(x.lat);
        id_varlat = x.vl; flush = x.fl; wb_valid = x.wbv; wb_rd = AW'(x.wbrd);
    endtask

    task automatic step(vec_t x, bit tab);
        bit h, iss;
        @(negedge clk);
        apply(x);
        #1;
        h = hz_m(x);
        chk("hz", hz, h);
        chk("hz_cw4", hz4, h);
        if (tab) chk("table_hz", hz, x.ehz);
        chk("sb_busy", sb_busy, busy_m());
        chk("stall_cycles", stall_cycles, sat(stall_m, 65535));
        chk("stall_cw4", stall4, sat(stall_m, 15));
        @(posedge clk);
        iss = x.v && !h && !x.fl;
        if (x.wbv && x.wbrd != 0) pend_m[x.wbrd] = 1'b0;
        if (iss && x.rw && x.rd != 0) begin
            if (x.vl) begin
                pend_m[x.rd]  = 1'b1;
                done_at[x.rd] = cyc;
            end else
                done_at[x.rd] = cyc + 1 + x.lat + BR;
        end
        if (h) stall_m++;
        cyc++;
    endtask

    vec_t tbl[$];
    vec_t idle, x;

    initial begin
        model_reset();
        idle = mk(0, 0,0, 0,0, 0, 0,0, 0,0, 0, 0);
        apply(idle);

        //       v rs1 u1 rs2 u2 br rd rw lat vl fl ehz
        tbl.push_back(mk(1, 0,0, 0,0, 0, 5,1, 1,0, 0, 0)); // load x5
        tbl.push_back(mk(1, 5,1, 0,0, 0, 6,1, 0,0, 0, 1)); // add x6,x5: load-use
        tbl.push_back(mk(1, 5,1, 0,0, 0, 6,1, 0,0, 0, 0));
        tbl.push_back(mk(1, 0,0, 0,0, 0, 7,1, 0,0, 0, 0)); // alu x7
        tbl.push_back(mk(1, 7,1, 0,0, 1, 0,0, 0,0, 0, 1)); // beq x7
        tbl.push_back(mk(1, 7,1, 0,0, 1, 0,0, 0,0, 0, 0));
        tbl.push_back(mk(1, 0,0, 0,0, 0, 7,1, 1,0, 0, 0)); // load x7
        tbl.push_back(mk(1, 0,0, 7,1, 1, 0,0, 0,0, 0, 1)); // beq via rs2
        tbl.push_back(mk(1, 0,0, 7,1, 1, 0,0, 0,0, 0, 1));
        tbl.push_back(mk(1, 0,0, 7,1, 1, 0,0, 0,0, 0, 0));
        tbl.push_back(mk(1, 0,0, 0,0, 0, 7,1, 0,0, 0, 0)); // alu x7
        tbl.push_back(mk(1, 7,0, 0,0, 1, 0,0, 0,0, 0, 0)); // beq, rs1 unused
        tbl.push_back(mk(1, 0,0, 0,0, 0, 3,1, 2,0, 0, 0)); // mul x3
        tbl.push_back(mk(1, 0,0, 0,0, 0, 3,1, 1,0, 0, 1)); // load x3: WAW
        tbl.push_back(mk(1, 0,0, 0,0, 0, 3,1, 1,0, 0, 0));
        tbl.push_back(idle);
        tbl.push_back(mk(1, 0,0, 0,0, 0, 3,1, 0,0, 0, 0)); // alu x3: no WAW
        tbl.push_back(mk(1, 0,0, 0,0, 0, 0,1, 1,0, 0, 0)); // load x0
        tbl.push_back(mk(1, 0,1, 0,1, 0, 0,1, 2,0, 0, 0)); // reads/writes x0
        tbl.push_back(mk(1, 0,0, 0,0, 0, 5,1, 1,0, 0, 0)); // load x5
        tbl.push_back(mk(1, 5,1, 0,0, 1, 0,0, 0,0, 1, 0)); // beq x5 flushed
        tbl.push_back(mk(1, 5,1, 0,0, 1, 0,0, 0,0, 0, 1));
        tbl.push_back(mk(1, 5,1, 0,0, 1, 0,0, 0,0, 0, 0));
        tbl.push_back(mk(1, 0,0, 0,0, 0, 8,1, 2,0, 1, 0)); // mul x8 flushed
        tbl.push_back(mk(1, 8,1, 0,0, 0, 0,0, 0,0, 0, 0)); // x8 never tracked

        #12;
        chk("rst_hz", hz, 0);
        chk("rst_busy", sb_busy, 0);
        chk("rst_stall", stall_cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], 1'b1);

        // divide: consumer waits through the write-back cycle
        step(mk(1, 0,0, 0,0, 0, 9,1, 0,1, 0, 0), 1'b1);
        for (int i = 0; i < 10; i++) begin
            x = mk(1, 9,1, 0,0, 0, 10,1, 0,0, 0, 1);
            if (i == 9) x = wbx(x, 9);
            step(x, 1'b1);
        end
        step(mk(1, 9,1, 0,0, 0, 10,1, 0,0, 0, 0), 1'b1);
        // new divide to x9 alongside a write-back for x9 keeps it pending
        step(wbx(mk(1, 0,0, 0,0, 0, 9,1, 0,1, 0, 0), 9), 1'b1);
        step(mk(1, 0,0, 9,1, 0, 0,0, 0,0, 0, 1), 1'b1);
        step(wbx(idle, 9), 1'b1);
        step(mk(1, 0,0, 9,1, 0, 0,0, 0,0, 0, 0), 1'b1);

        // asynchronous reset in the middle of a mul countdown
        step(mk(1, 0,0, 0,0, 0, 4,1, 2,0, 0, 0), 1'b1);
        @(negedge clk);
        apply(mk(1, 4,1, 0,0, 0, 0,0, 0,0, 0, 1));
        #1;
        chk("pre_rst_hz", hz, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_hz", hz, 0);
        chk("midrst_busy", sb_busy, 0);
        chk("midrst_stall", stall_cycles, 0);
        chk("midrst_stall_cw4", stall4, 0);
        model_reset();
        @(negedge clk);
        apply(idle);
        rst_n = 1'b1;

        // 20 stalls against a pending divide: CW=4 counter pins at 15
        step(mk(1, 0,0, 0,0, 0, 5,1, 0,1, 0, 0), 1'b1);
        for (int i = 0; i < 20; i++) step(mk(1, 5,1, 0,0, 0, 6,1, 0,0, 0, 1), 1'b1);
        step(wbx(idle, 5), 1'b1);
        chk("sat_cw4", stall4, 15);
        chk("count_cw16", stall_cycles, 20);

        for (int i = 0; i < 1500; i++) begin
            x.v = ($urandom % 4) != 0;
            x.rs1 = $urandom % 8; x.u1 = $urandom % 2;
            x.rs2 = $urandom % 8; x.u2 = $urandom % 2;
            x.br = ($urandom % 5) == 0;
            x.rd = $urandom % 8; x.rw = ($urandom % 3) != 0;
            x.lat = $urandom_range(0, MAXLAT);
            x.vl = ($urandom % 8) == 0;
            x.fl = ($urandom % 10) == 0;
            x.wbv = ($urandom % 4) == 0; x.wbrd = $urandom % 8;
            x.ehz = 1'b0;
            step(x, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
